// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch
// and the MEM stage, generating the pipeline stall and a sticky bus-timeout flag.
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          stall,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, D_ISSUE, D_WAIT, F_ISSUE, F_WAIT} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          bus_err_q, bus_err_d;

    logic d_req, d_go, f_go, timed_out;

    assign d_req     = d_rd | d_wr;
    // A requester still holds its request during its own done cycle; masking
    // it there keeps the finished access from being granted a second time.
    assign d_go      = d_req & ~d_done_q;
    assign f_go      = if_req & ~if_done_q;
    assign timed_out = (cnt_q == TMO);

    assign stall     = (d_req & ~d_done_q) | (if_req & ~if_done_q);
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = bus_err_q;

        if (state_q != IDLE && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (d_go && (!f_go || !last_data_q)) begin
                    state_d     = D_ISSUE;
                    last_data_d = 1'b1;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (f_go) begin
                    state_d     = F_ISSUE;
                    last_data_d = 1'b0;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                end
            end
            D_ISSUE, F_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == D_ISSUE && mem_we_q) begin
                        state_d  = IDLE;
                        d_done_d = 1'b1;
                    end else begin
                        state_d = (state_q == D_ISSUE) ? D_WAIT : F_WAIT;
                    end
                end else if (timed_out) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == D_ISSUE) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end
            end
            D_WAIT: begin
                if (mem_rvalid || timed_out) begin
                    state_d   = IDLE;
                    d_done_d  = 1'b1;
                    d_rdata_d = mem_rvalid ? mem_rdata : '0;
                    bus_err_d = bus_err_q | ~mem_rvalid;
                end
            end
            F_WAIT: begin
                if (mem_rvalid || timed_out) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rvalid ? mem_rdata : '0;
                    bus_err_d  = bus_err_q | ~mem_rvalid;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a transaction-level memory/latency model drives
// randomized and directed accesses and checks data, timing, stall and bus_err.
module tb_unified_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_rd, d_wr;
    logic [31:0] d_addr, d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        stall, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .stall(stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    bit exp_bus_err = 1'b0;

    // Expected memory contents (requester view) and the responder's storage (bus view).
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    // Memory responder configuration and state
    int          rdy_wait, rv_wait, rdy_delay, rv_delay;
    bit          rv_never, rv_pending, accepting;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then update the memory responder for the new cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (accepting) begin
            if (acc_we) phys_mem[acc_addr] = acc_wdata;
            else begin
                rv_pending = 1'b1;
                rv_delay   = rv_wait;
            end
            accepting = 1'b0;
        end
        mem_rvalid = 1'b0;
        if (rv_pending && !rv_never) begin
            if (rv_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = phys_rd(acc_addr);
                rv_pending = 1'b0;
            end else rv_delay--;
        end
        mem_ready = 1'b0;
        if (mem_req) begin
            if (rdy_delay == 0) mem_ready = 1'b1;
            else rdy_delay--;
        end else rdy_delay = rdy_wait;
        accepting = mem_req && mem_ready;
        acc_addr  = mem_addr;
        acc_we    = mem_we;
        acc_wdata = mem_wdata;
    endtask

    task automatic set_mem(input int r, input int v, input bit never);
        rdy_wait   = r;
        rdy_delay  = r;
        rv_wait    = v;
        rv_never   = never;
        rv_pending = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 fetch. r = ready wait states, v = rvalid delay.
    task automatic do_acc(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input int r, input int v, input bit never);
        int lat, mreq, exp_lat;
        bit seen, done;
        set_mem(r, v, never);
        case (kind)
            0: begin d_rd = 1'b1; d_addr = addr; end
            1: begin d_wr = 1'b1; d_addr = addr; d_wdata = wdata; end
            default: begin if_req = 1'b1; if_addr = addr; end
        endcase
        lat = 0; mreq = 0; seen = 1'b0;
        while (!seen && lat < 60) begin
            cycle();
            lat++;
            done = (kind == 2) ? if_done : d_done;
            if (done) seen = 1'b1;
            else begin
                chk("stall_busy", 32'(stall), 32'd1);
                if (mem_req) begin
                    mreq++;
                    chk("mem_addr", mem_addr, addr);
                    chk("mem_we", 32'(mem_we), 32'(kind == 1));
                    if (kind == 1) chk("mem_wdata", mem_wdata, wdata);
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        exp_lat = never ? TMO + 2 : ((kind == 1) ? r + 2 : r + 3 + v);
        chk("latency", lat, exp_lat);
        chk("mreq_cycles", mreq, r + 1);
        chk("stall_done", 32'(stall), 32'd0);
        if (never) exp_bus_err = 1'b1;
        chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
        if (kind == 0) chk("d_rdata", d_rdata, never ? 32'd0 : ref_rd(addr));
        if (kind == 2) chk("if_rdata", if_rdata, never ? 32'd0 : ref_rd(addr));
        if (kind == 1 && !never) ref_mem[addr] = wdata;
        d_rd = 1'b0; d_wr = 1'b0; if_req = 1'b0;
        d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
        cycle();
        chk("done_pulse", 32'((kind == 2) ? if_done : d_done), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int kind, r, v;
        logic [31:0] a;
        int got_q[$];

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        accepting = 1'b0;
        set_mem(0, 0, 1'b0);
        phys_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100]  = 32'hDEADBEEF;

        cycle(); cycle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Contention from reset release: data first, then strict alternation.
        d_rd = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h200;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
            cycle();
            chk("stall_contend", 32'(stall), 32'd1);
            if (d_done) begin
                got_q.push_back(1);
                chk("contend_d_rdata", d_rdata, ref_rd(32'h300));
            end
            if (if_done) begin
                got_q.push_back(2);
                chk("contend_if_rdata", if_rdata, ref_rd(32'h200));
            end
        end
        chk("contend_count", got_q.size(), 4);
        foreach (got_q[i]) chk("grant_order", got_q[i], (i % 2 == 0) ? 1 : 2);
        d_rd = 1'b0; if_req = 1'b0;
        cycle(); cycle();

        do_acc(0, 32'h100, '0, 0, 0, 1'b0);
        do_acc(1, 32'h40, 32'h12345678, 2, 0, 1'b0);
        do_acc(0, 32'h40, '0, 1, 2, 1'b0);

        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 2);
            a    = 32'($urandom_range(0, 3)) << 8;
            r    = $urandom_range(0, 3);
            v    = $urandom_range(0, 3);
            do_acc(kind, a, $urandom, r, v, 1'b0);
        end

        // Completion exactly at the timeout count is not an error.
        do_acc(0, 32'h200, '0, 0, TMO - 1, 1'b0);
        do_acc(1, 32'h300, 32'hCAFEF00D, TMO, 0, 1'b0);
        do_acc(2, 32'h300, '0, 0, 0, 1'b0);

        // Fetch whose read data never arrives, then bus_err must stay set.
        do_acc(2, 32'h100, '0, 0, 0, 1'b1);
        do_acc(0, 32'h40, '0, 0, 1, 1'b0);
        do_acc(2, 32'h200, '0, 1, 0, 1'b0);

        // Asynchronous reset while a load waits for read data.
        set_mem(0, 5, 1'b0);
        d_rd = 1'b1; d_addr = 32'h300;
        cycle(); cycle(); cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        chk("arst_if_done", 32'(if_done), 32'd0);
        chk("arst_d_done", 32'(d_done), 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_d_rdata", d_rdata, 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        exp_bus_err = 1'b0;
        d_rd = 1'b0;
        accepting = 1'b0; rv_pending = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_acc(2, 32'h300, '0, 0, 0, 1'b0);
        do_acc(0, 32'h100, '0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
